pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_hazard_ctrl                                           |
// | Description : Hazard unit for a 6-stage in-order pipeline (F D E M1 M2   |
// |               W). Resolves operand forwarding, load-use stalls, branch   |
// |               flushes and multi-cycle divide stalls, and optionally      |
// |               counts stall/flush cycles.                                 |
// | Config      : `define PIPE_HAZARD_CTRL_PERF_EN to build the stall/flush  |
// |               performance counters; without it they read constant 0.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [4:0]       rd_m1,
  input  logic [4:0]       rd_m2,
  input  logic [4:0]       rd_w,
  input  logic             regwrite_e,
  input  logic             regwrite_m1,
  input  logic             regwrite_m2,
  input  logic             regwrite_w,
  input  logic             load_e,
  input  logic             load_m1,
  input  logic             pcsrc_e,
  input  logic             div_e,
  input  logic             div_done,
  output logic             div_start,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m1,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  div_state_e state_q, state_d;

  logic div_go;    // divide launches this cycle
  logic div_hold;  // pipeline frozen behind the divider
  logic luh;       // load-use hazard on either Decode source

  // Youngest producer wins: M1 holds the most recent value, then M2, then W.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (regwrite_m1 && (rd_m1 != 5'd0) && (rd_m1 == rs)) return 2'b11;
    if (regwrite_m2 && (rd_m2 != 5'd0) && (rd_m2 == rs)) return 2'b10;
    if (regwrite_w  && (rd_w  != 5'd0) && (rd_w  == rs)) return 2'b01;
    return 2'b00;
  endfunction

  // A load still in E or M1 has no data yet for a consumer in Decode.
  function automatic logic load_hit(input logic [4:0] rs);
    return (load_e  && regwrite_e  && (rd_e  != 5'd0) && (rd_e  == rs)) ||
           (load_m1 && regwrite_m1 && (rd_m1 != 5'd0) && (rd_m1 == rs));
  endfunction

  assign luh      = load_hit(rs1_d) || load_hit(rs2_d);
  assign div_go   = (state_q == IDLE) && div_e && !pcsrc_e;
  assign div_hold = div_go || (state_q == BUSY);

  // Operand forwarding selects for the instruction in Execute.
  always_comb begin
    fwd_a_e = fwd_sel(rs1_e);
    fwd_b_e = fwd_sel(rs2_e);
  end

  // Divide state register; reset abandons any divide in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Divide next state plus stall/flush arbitration: divide > branch > load-use.
  // A divide in BUSY owns Execute, so it also outranks a branch seen then.
  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_m1  = 1'b0;

    case (state_q)
      IDLE:    if (div_go)   state_d = BUSY;
      BUSY:    if (div_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (!reset) begin
      div_start = div_go;
      if (div_hold) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_e  = 1'b1;
        flush_m1 = 1'b1;
      end else if (pcsrc_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (luh) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Free-running stall/flush cycle counters, wrapping at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_d || flush_e || flush_m1) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pipe_hazard_ctrl                                        |
// | Description : Self-checking bench for pipe_hazard_ctrl: directed hazard  |
// |               scenarios followed by randomized traffic against a         |
// |               behavioural reference model.                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m1, rd_m2, rd_w;
  logic regwrite_e, regwrite_m1, regwrite_m2, regwrite_w;
  logic load_e, load_m1, pcsrc_e, div_e, div_done;
  logic div_start, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m1;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: divide phase 0 = idle, 1 = waiting on divider,
  // 2 = result cycle; counters kept as plain integers.
  int phase = 0;
  int m_stall_cnt = 0;
  int m_flush_cnt = 0;
  logic e_div_start, e_stall_f, e_stall_d, e_stall_e;
  logic e_flush_d, e_flush_e, e_flush_m1;
  logic [1:0] e_fwd_a, e_fwd_b;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd_m1(rd_m1), .rd_m2(rd_m2), .rd_w(rd_w),
    .regwrite_e(regwrite_e), .regwrite_m1(regwrite_m1),
    .regwrite_m2(regwrite_m2), .regwrite_w(regwrite_w),
    .load_e(load_e), .load_m1(load_m1), .pcsrc_e(pcsrc_e),
    .div_e(div_e), .div_done(div_done), .div_start(div_start),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m1(flush_m1),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scan the producer stages from youngest to oldest.
  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    logic [4:0] dst [3];
    logic       wen [3];
    dst = '{rd_m1, rd_m2, rd_w};
    wen = '{regwrite_m1, regwrite_m2, regwrite_w};
    for (int i = 0; i < 3; i++)
      if (wen[i] && dst[i] != 5'd0 && dst[i] == rs) return 2'(3 - i);
    return 2'b00;
  endfunction

  function automatic bit ref_waits_on_load(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    return (load_e && regwrite_e && rd_e == rs) || (load_m1 && regwrite_m1 && rd_m1 == rs);
  endfunction

  task automatic model_eval();
    bit go, hold, hazard;
    if (reset) begin
      phase = 0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end
    go     = !reset && phase == 0 && div_e && !pcsrc_e;
    hold   = go || phase == 1;
    hazard = ref_waits_on_load(rs1_d) || ref_waits_on_load(rs2_d);
    {e_div_start, e_stall_f, e_stall_d, e_stall_e, e_flush_d, e_flush_e, e_flush_m1} = '0;
    if (!reset) begin
      e_div_start = go;
      if (hold)         {e_stall_f, e_stall_d, e_stall_e, e_flush_m1} = 4'b1111;
      else if (pcsrc_e) {e_flush_d, e_flush_e} = 2'b11;
      else if (hazard)  {e_stall_f, e_stall_d, e_flush_e} = 3'b111;
    end
    e_fwd_a = ref_fwd(rs1_e);
    e_fwd_b = ref_fwd(rs2_e);
  endtask

  // Mid-cycle: compare every output against the model.
  task automatic sample();
    @(negedge clk);
    model_eval();
    check_val("div_start", div_start, e_div_start);
    check_val("stall_f", stall_f, e_stall_f);
    check_val("stall_d", stall_d, e_stall_d);
    check_val("stall_e", stall_e, e_stall_e);
    check_val("flush_d", flush_d, e_flush_d);
    check_val("flush_e", flush_e, e_flush_e);
    check_val("flush_m1", flush_m1, e_flush_m1);
    check_val("fwd_a_e", fwd_a_e, e_fwd_a);
    check_val("fwd_b_e", fwd_b_e, e_fwd_b);
    check_val("stall_cnt", stall_cnt, m_stall_cnt);
    check_val("flush_cnt", flush_cnt, m_flush_cnt);
  endtask

  // Clock edge: advance the model, then let inputs change just after.
  task automatic advance();
    @(posedge clk);
    if (reset) begin
      phase = 0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      case (phase)
        0: if (e_div_start) phase = 1;
        1: if (div_done) phase = 2;
        default: phase = 0;
      endcase
      if (PERF != 0 && e_stall_f) m_stall_cnt = (m_stall_cnt + 1) % (1 << CNT_W);
      if (PERF != 0 && (e_flush_d || e_flush_e || e_flush_m1))
        m_flush_cnt = (m_flush_cnt + 1) % (1 << CNT_W);
    end
    #1;
  endtask

  task automatic clear_inputs();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m1, rd_m2, rd_w} = '0;
    {regwrite_e, regwrite_m1, regwrite_m2, regwrite_w} = '0;
    {load_e, load_m1, pcsrc_e, div_e, div_done} = '0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;

    // Reset state
    sample();
    check_val("rst_stall_f", stall_f, 1'b0);
    check_val("rst_stall_cnt", stall_cnt, 0);
    advance();
    reset = 1'b0;

    // Forwarding priority M1 > M2 > W
    rs1_e = 5'd5; rd_m1 = 5'd5; rd_m2 = 5'd5; rd_w = 5'd5;
    {regwrite_m1, regwrite_m2, regwrite_w} = 3'b111;
    sample(); check_val("fwd_prio_m1", fwd_a_e, 2'b11); advance();
    regwrite_m1 = 1'b0;
    sample(); check_val("fwd_prio_m2", fwd_a_e, 2'b10); advance();
    rd_w = 5'd0; rs1_e = 5'd0;
    sample(); check_val("fwd_x0", fwd_a_e, 2'b00); advance();

    // Load-use: load x7 in E, consumer of x7 in D
    clear_inputs();
    load_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
    sample();
    check_val("luh1_stall", {stall_f, stall_d, flush_e}, 3'b111);
    advance();
    load_e = 1'b0; regwrite_e = 1'b0; rd_e = 5'd0;
    load_m1 = 1'b1; regwrite_m1 = 1'b1; rd_m1 = 5'd7;
    sample();
    check_val("luh2_stall", {stall_f, stall_d, flush_e}, 3'b111);
    advance();
    load_m1 = 1'b0; regwrite_m1 = 1'b0; rd_m1 = 5'd0;
    regwrite_m2 = 1'b1; rd_m2 = 5'd7; rs2_d = 5'd0; rs2_e = 5'd7;
    sample();
    check_val("luh_release", {stall_f, stall_d, flush_e}, 3'b000);
    check_val("luh_fwd_b", fwd_b_e, 2'b10);
    advance();

    // Branch beats load-use
    clear_inputs();
    load_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7; pcsrc_e = 1'b1;
    sample();
    check_val("br_flush", {flush_d, flush_e}, 2'b11);
    check_val("br_nostall", {stall_f, stall_d}, 2'b00);
    advance();

    // Divide with div_done after 5 cycles, then a stray div_done
    clear_inputs();
    div_e = 1'b1;
    sample();
    check_val("div_go", {div_start, stall_e, flush_m1, flush_e}, 4'b1110);
    advance();
    for (int k = 1; k <= 5; k++) begin
      div_done = (k == 5);
      sample();
      check_val("div_busy", {div_start, stall_e, flush_m1, flush_e}, 4'b0110);
      advance();
    end
    div_done = 1'b0;
    sample();
    check_val("div_done_free", {div_start, stall_f, stall_d, stall_e}, 4'b0000);
    advance();
    div_e = 1'b0; div_done = 1'b1;
    sample(); check_val("div_stray", {div_start, stall_e}, 2'b00); advance();
    div_done = 1'b0;
    sample(); check_val("div_idle", {div_start, stall_e}, 2'b00); advance();

    // Reset during BUSY
    div_e = 1'b1;
    sample(); advance();
    sample(); advance();
    sample(); advance();
    reset = 1'b1; div_e = 1'b0;
    sample();
    check_val("rst_busy_outs", {div_start, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m1}, 7'd0);
    advance();
    reset = 1'b0; div_done = 1'b1;
    sample(); check_val("rst_late_done", {div_start, stall_e}, 2'b00); advance();
    div_done = 1'b0;
    sample(); check_val("rst_idle", {div_start, stall_e}, 2'b00); advance();

    // Counter wrap: 2^CNT_W-1 stall cycles, then one more
    clear_inputs();
    reset = 1'b1;
    sample(); advance();
    reset = 1'b0;
    load_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd3; rs1_d = 5'd3;
    for (int k = 0; k < (1 << CNT_W) - 1; k++) begin
      sample(); advance();
    end
    sample();
    check_val("cnt_preload", stall_cnt, PERF * ((1 << CNT_W) - 1));
    advance();
    sample();
    check_val("cnt_wrap", stall_cnt, 0);
    advance();

    // Randomized traffic on a small register window to force matches
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 63) == 0);
      rs1_d       = 5'($urandom_range(0, 3));
      rs2_d       = 5'($urandom_range(0, 3));
      rs1_e       = 5'($urandom_range(0, 3));
      rs2_e       = 5'($urandom_range(0, 3));
      rd_e        = 5'($urandom_range(0, 3));
      rd_m1       = 5'($urandom_range(0, 3));
      rd_m2       = 5'($urandom_range(0, 3));
      rd_w        = 5'($urandom_range(0, 3));
      regwrite_e  = 1'($urandom_range(0, 1));
      regwrite_m1 = 1'($urandom_range(0, 1));
      regwrite_m2 = 1'($urandom_range(0, 1));
      regwrite_w  = 1'($urandom_range(0, 1));
      load_e      = 1'($urandom_range(0, 1));
      load_m1     = 1'($urandom_range(0, 1));
      pcsrc_e     = (phase != 1) && ($urandom_range(0, 7) == 0);
      div_e       = ($urandom_range(0, 5) == 0);
      div_done    = ($urandom_range(0, 3) == 0);
      sample();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
